// File: rtl/imem_program_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the
// core in reset until the image is fully written.
module imem_program_loader #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        core_rst_n
);

    // Byte stream handshake: a byte transfers on any rising clk edge where
    // byte_valid and byte_ready are both 1. byte_ready depends only on the
    // registered state. The source must hold byte_data until it transfers.

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        load_q;
    logic        load_rise;
    logic [15:0] len;
    logic [15:0] len_full;
    logic        len_bad;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [31:0] word;
    logic        last_word;
    logic        accept;

    assign load_rise = load_en & ~load_q;
    assign len_full  = {byte_data, len[7:0]};
    assign len_bad   = (len_full == 16'd0) || ({16'h0, len_full} > 32'(DEPTH));
    assign last_word = (word_idx == len - 16'd1);
    assign accept    = byte_valid & byte_ready;

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        core_rst_n = 1'b1;
        case (state)
            S_IDLE: begin
                if (load_rise) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                core_rst_n = 1'b0;
                if (byte_valid) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                core_rst_n = 1'b0;
                if (byte_valid) state_nxt = len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                core_rst_n = 1'b0;
                if (byte_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we     = 1'b1;
                busy       = 1'b1;
                core_rst_n = 1'b0;
                state_nxt  = last_word ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done = 1'b1;
                if (load_rise) state_nxt = S_LEN_LO;
            end
            S_ERR: begin
                error      = 1'b1;
                core_rst_n = 1'b0;
                if (load_rise) state_nxt = S_LEN_LO;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            load_q    <= 1'b0;
            len       <= 16'd0;
            word_idx  <= 16'd0;
            byte_idx  <= 2'd0;
            word      <= 32'd0;
            mem_waddr <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            state  <= state_nxt;
            load_q <= load_en;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (load_rise) begin
                        word_idx <= 16'd0;
                        byte_idx <= 2'd0;
                    end
                end
                S_LEN_LO: if (accept) len[7:0]  <= byte_data;
                S_LEN_HI: if (accept) len[15:8] <= byte_data;
                S_DATA: begin
                    if (accept) begin
                        word[{byte_idx, 3'b000} +: 8] <= byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Address and data are captured once per word so the
                        // write port stays stable between strobes.
                        if (byte_idx == 2'd3) begin
                            mem_wdata <= {byte_data, word[23:0]};
                            mem_waddr <= BASE_ADDR + ({16'h0, word_idx} << 2);
                        end
                    end
                end
                S_WRITE: if (!last_word) word_idx <= word_idx + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: vector table of whole loads plus
// hand sequences for depth boundary, ignored restart and reset mid-load.
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_rst_n;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];

    imem_program_loader #(.DEPTH(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .error(error), .core_rst_n(core_rst_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [7:0]  bytes [12];
        int          nbytes;
        int          gap;
        logic [31:0] words [2];
        int          nwords;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write scoreboard: every strobe must match the oldest expected {addr,data}.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h required=none", {mem_waddr, mem_wdata});
            end else begin
                chk("write", {mem_waddr, mem_wdata}, exp_q.pop_front());
            end
            chk("ready_in_write", 64'(byte_ready), 64'd0);
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd1);
        chk({tag, "_mem_waddr"}, 64'(mem_waddr), 64'd0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    task automatic start_load();
        load_en = 1'b1;
        step();
        chk("start_ready", 64'(byte_ready), 64'd1);
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_core_rst_n", 64'(core_rst_n), 64'd0);
        load_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual=stalled required=byte_ready");
        end
        step();
        byte_valid = 1'b0;
    endtask

    // Called right after the last data byte is accepted.
    task automatic finish_ok(input string tag);
        chk({tag, "_last_we"}, 64'(mem_we), 64'd1);
        step();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        step();
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_vec(input int k);
        for (int i = 0; i < vecs[k].nwords; i++)
            exp_q.push_back({32'(4 * i), vecs[k].words[i]});
        start_load();
        for (int i = 0; i < vecs[k].nbytes; i++) send_byte(vecs[k].bytes[i], vecs[k].gap);
        if (vecs[k].exp_err) begin
            chk({vecs[k].name, "_error"}, 64'(error), 64'd1);
            chk({vecs[k].name, "_done"}, 64'(done), 64'd0);
            chk({vecs[k].name, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
            chk({vecs[k].name, "_byte_ready"}, 64'(byte_ready), 64'd0);
            step();
            step();
            chk({vecs[k].name, "_err_hold"}, 64'(error), 64'd1);
            chk({vecs[k].name, "_pending"}, 64'(exp_q.size()), 64'd0);
        end else begin
            finish_ok(vecs[k].name);
        end
    endtask

    initial begin
        logic [31:0] w;

        vecs[0] = '{"normal", '{8'h02, 8'h00, 8'h13, 8'h01, 8'h80, 8'h00, 8'h93, 8'h00,
                    8'h40, 8'h00, 8'h00, 8'h00}, 10, 0, '{32'h00800113, 32'h00400093}, 2, 1'b0};
        vecs[1] = '{"backpressure", '{8'h02, 8'h00, 8'h13, 8'h01, 8'h80, 8'h00, 8'h93, 8'h00,
                    8'h40, 8'h00, 8'h00, 8'h00}, 10, 3, '{32'h00800113, 32'h00400093}, 2, 1'b0};
        vecs[2] = '{"zero_len", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, '{32'h0, 32'h0}, 0, 1'b1};
        vecs[3] = '{"oversize", '{8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, '{32'h0, 32'h0}, 0, 1'b1};
        vecs[4] = '{"retry_one", '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00}, 6, 1, '{32'hDEADBEEF, 32'h0}, 1, 1'b0};
        vecs[5] = '{"high_len", '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, '{32'h0, 32'h0}, 0, 1'b1};

        rst = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b1;
        step();

        for (int k = 0; k < 6; k++) run_vec(k);

        // load_en toggling mid-transfer must not restart the load
        exp_q.push_back({32'h0, 32'h00800113});
        exp_q.push_back({32'h4, 32'h00400093});
        start_load();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h01, 0);
        load_en = 1'b1;
        step();
        chk("restart_busy", 64'(busy), 64'd1);
        load_en = 1'b0;
        step();
        chk("restart_ready", 64'(byte_ready), 64'd1);
        send_byte(8'h80, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h40, 0);
        send_byte(8'h00, 0);
        finish_ok("restart");

        // reload after done starts again at the base address
        exp_q.push_back({32'h0, 32'hCAFEF00D});
        start_load();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0D, 0);
        send_byte(8'hF0, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hCA, 0);
        finish_ok("reload");

        // exactly DEPTH words is the largest legal image
        start_load();
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 32; i++) begin
            w = (32'h01020304 * 32'(i + 1)) ^ 32'hA5A55A5A;
            exp_q.push_back({32'(4 * i), w});
            for (int b = 0; b < 4; b++) send_byte(w[8 * b +: 8], 0);
        end
        finish_ok("depth");

        // reset in the middle of a word
        start_load();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b0;
        step();
        chk_reset_outputs("midreset");
        rst = 1'b1;
        step();
        exp_q.push_back({32'h0, 32'h12345678});
        start_load();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        finish_ok("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Loads a program into the instruction memory before the core runs. It receives a byte stream through a valid/ready handshake and parses a 16-bit little-endian word-count header. It packs each following group of four bytes into a little-endian 32-bit word and writes it through the memory write port at consecutive word addresses. It holds the core in reset while loading and reports completion or a header error.

## Interface
- DEPTH, 32, instruction memory size in 32-bit words; the largest legal word count.
- BASE_ADDR, 32'h0, byte address of the first written word.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- load_en  in  1  start request; a rising edge (0 to 1 between consecutive clock samples) starts a load.
- byte_valid  in  1  byte_data holds a valid byte.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  one-cycle instruction memory write strobe.
- mem_waddr  out  32  byte address of the write (always a multiple of 4).
- mem_wdata  out  32  word being written.
- busy  out  1  a load is in progress.
- done  out  1  the last load completed successfully (level).
- error  out  1  the last load was rejected (level).
- core_rst_n  out  1  active-low hold for the core; 0 while loading or in error.

## Operation
- Moore FSM with states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR. All outputs are decoded from registered state and data registers.
- A byte is accepted when byte_valid and byte_ready are both 1 on the same clock edge.
- IDLE:
  - byte_ready=0, busy=0, core_rst_n=1.
  - A load_en rising edge moves to LEN_LO and clears word_idx, byte_idx, done and error.
- LEN_LO: byte_ready=1; an accepted byte goes to len[7:0]; move to LEN_HI.
- LEN_HI:
  - byte_ready=1; an accepted byte goes to len[15:8].
  - If the resulting len is 0 or greater than DEPTH, move to ERR. Otherwise move to DATA.
- DATA:
  - byte_ready=1; each accepted byte goes to word[8*byte_idx +: 8], so the first byte is the LSB.
  - byte_idx is 2 bits and increments on each accept.
  - Accepting the byte at byte_idx=3 moves to WRITE, and byte_idx wraps to 0.
- WRITE:
  - byte_ready=0, mem_we=1, mem_waddr=BASE_ADDR + 4*word_idx, mem_wdata=the assembled word.
  - Next state: DONE if word_idx == len-1; otherwise DATA with word_idx+1.
- DONE: done=1, core_rst_n=1, byte_ready=0. A load_en rising edge starts a new load in LEN_LO.
- ERR: error=1, core_rst_n=0, byte_ready=0. A load_en rising edge starts a new load in LEN_LO.
- busy=1 in LEN_LO, LEN_HI, DATA and WRITE. core_rst_n=0 in those states and in ERR.
- load_en edges during busy states are ignored, so a load cannot restart mid-transfer.
- Bytes offered while byte_ready=0 are not consumed; the source must hold them.
- mem_waddr and mem_wdata are held stable whenever mem_we=0. Their value then is don't-care but must not produce X.

## Timing
- Reset (rst=0 at a clock edge) forces the following, regardless of state, including mid-load:
  - state=IDLE, mem_we=0, byte_ready=0, busy=0, done=0, error=0, core_rst_n=1.
  - mem_waddr=0, mem_wdata=0, len=0, word_idx=0, byte_idx=0, load_en edge detector=0.
- Start latency: the load_en rising edge is sampled at edge N, and byte_ready=1 from the cycle after edge N.
- Per word, minimum 5 cycles: 4 accept cycles in DATA plus 1 WRITE cycle with byte_ready=0.
- mem_we rises in the cycle after the fourth byte of a word is accepted and lasts exactly one cycle.
- done and core_rst_n=1 are asserted in the cycle after the final WRITE cycle.
- Error timing: with a bad header, error=1 in the cycle after the LEN_HI byte is accepted, and no mem_we pulse occurs.
- Gaps in byte_valid stall the FSM indefinitely; there is no timeout.
- len is 16 bits and word_idx is 16 bits. Address arithmetic is 32-bit modulo 2^32.

## Test plan
- Normal load with DEPTH=32:
  - Stimulus: a load_en pulse, then stream 02 00 13 01 80 00 93 00 40 00 with no gaps.
  - Response: mem_we at addr 0 with 32'h00800113, then at addr 4 with 32'h00400093; done=1, core_rst_n=1.
- Zero length: header 00 00 -> error=1, no mem_we, core_rst_n=0, byte_ready=0.
- Oversize: header 21 00 (33 words) -> error=1, no writes. Then retry with a load_en edge and header 01 00 -> one write, done=1, error=0.
- Backpressure:
  - Stimulus: the normal-load stream with byte_valid low for 3 cycles between every byte.
  - Response: identical writes to the normal load; no byte is lost or duplicated; byte_ready=0 in every WRITE cycle.
- Reset mid-load: assert rst=0 after two data bytes -> next cycle IDLE with all outputs at their reset values. A fresh load then writes its first word at address 0.
- Ignored restart: load_en toggles during DATA -> no effect. After done, a new load_en edge reloads starting from BASE_ADDR.
